tmds_decoder: RTL and testbench

TMDS_DECODER -- requirements
Module: tmds_decoder

---
 rtl/tmds_decoder.sv | 172 +++++++++++++++++
 tb/tb_tmds_decoder.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/tmds_decoder.sv
// TMDS 8b/10b symbol decoder with control-token alignment FSM (search / bit-slip / lock).
// Optional lock-loss event counter on o_err_cnt is built when TMDS_DEC_ERR_CNT_EN is defined.
module tmds_decoder #(
  parameter int unsigned SEARCH_LEN = 4096,
  parameter int unsigned CTRL_RUN   = 8
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [9:0]  i_tmds,
  output logic [7:0]  o_pixel,
  output logic [1:0]  o_ctrl,
  output logic        o_de,
  output logic        o_locked,
  output logic        o_bitslip,
  output logic [15:0] o_err_cnt
);

  typedef enum logic [1:0] {SEARCH, SLIP_WAIT, LOCKED} state_t;

  localparam logic [15:0] WD_LAST = 16'(SEARCH_LEN - 1);
  localparam logic [7:0]  RUN_TGT = 8'(CTRL_RUN);

  state_t      state_q, state_d;
  logic [9:0]  tmds_q;
  logic        vld_q;
  logic [15:0] wd_q, wd_d, wd_inc, wd_cnt;
  logic [7:0]  run_q, run_d, run_inc, run_cnt;
  logic [2:0]  wait_q, wait_d;
  logic [7:0]  pixel_q, pixel_d;
  logic [1:0]  ctrl_q, ctrl_d;
  logic        de_q, de_d;
  logic        match, is_ctrl, is_data, bitslip;
  logic [1:0]  cval;
  logic [7:0]  qv, dec;

  // Stage 1: capture symbol; vld_q keeps the reset-cleared register from being decoded
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      tmds_q <= '0;
      vld_q  <= 1'b0;
    end else begin
      tmds_q <= i_tmds;
      vld_q  <= 1'b1;
    end
  end

  always_comb begin
    match = 1'b0;
    cval  = 2'b00;
    case (tmds_q)
      10'b1101010100: begin match = 1'b1; cval = 2'b00; end
      10'b0010101011: begin match = 1'b1; cval = 2'b01; end
      10'b0101010100: begin match = 1'b1; cval = 2'b10; end
      10'b1010101011: begin match = 1'b1; cval = 2'b11; end
      default:        begin match = 1'b0; cval = 2'b00; end
    endcase
    is_ctrl = vld_q & match;
    is_data = vld_q & ~match;
  end

  always_comb begin
    qv     = tmds_q[9] ? ~tmds_q[7:0] : tmds_q[7:0];
    dec    = '0;
    dec[0] = qv[0];
    for (int unsigned n = 1; n < 8; n++) begin
      dec[n] = tmds_q[8] ? (qv[n] ^ qv[n-1]) : ~(qv[n] ^ qv[n-1]);
    end
  end

  always_comb begin
    pixel_d = pixel_q;
    ctrl_d  = ctrl_q;
    de_d    = de_q;
    if (is_ctrl) begin
      de_d   = 1'b0;
      ctrl_d = cval;
    end else if (is_data) begin
      de_d    = 1'b1;
      pixel_d = dec;
    end
  end

  // Alignment FSM and counters
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    bitslip = 1'b0;
    wd_inc  = (wd_q == 16'hFFFF) ? wd_q : wd_q + 16'd1;
    run_inc = (run_q == 8'hFF) ? run_q : run_q + 8'd1;
    wd_cnt  = wd_q;
    run_cnt = run_q;
    if (is_ctrl) begin
      wd_cnt  = '0;
      run_cnt = run_inc;
    end else if (is_data) begin
      wd_cnt  = wd_inc;
      run_cnt = '0;
    end
    wd_d  = wd_cnt;
    run_d = run_cnt;
    case (state_q)
      SEARCH: begin
        if (is_ctrl && run_inc == RUN_TGT) begin
          state_d = LOCKED;
        end else if (is_data && wd_q == WD_LAST) begin
          state_d = SLIP_WAIT;
          bitslip = 1'b1;
          wd_d    = '0;
          run_d   = '0;
          wait_d  = '0;
        end
      end
      SLIP_WAIT: begin
        wd_d   = '0;
        run_d  = '0;
        wait_d = wait_q + 3'd1;
        if (wait_q == 3'd7) state_d = SEARCH;
      end
      LOCKED: begin
        if (is_data && wd_q == WD_LAST) begin
          state_d = SEARCH;
          wd_d    = '0;
          run_d   = '0;
        end
      end
      default: state_d = SEARCH;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= SEARCH;
      wd_q    <= '0;
      run_q   <= '0;
      wait_q  <= '0;
      pixel_q <= '0;
      ctrl_q  <= '0;
      de_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      wd_q    <= wd_d;
      run_q   <= run_d;
      wait_q  <= wait_d;
      pixel_q <= pixel_d;
      ctrl_q  <= ctrl_d;
      de_q    <= de_d;
    end
  end

  assign o_pixel   = pixel_q;
  assign o_ctrl    = ctrl_q;
  assign o_de      = de_q;
  assign o_locked  = (state_q == LOCKED);
  assign o_bitslip = bitslip;

`ifdef TMDS_DEC_ERR_CNT_EN
  logic [15:0] err_q;
  logic        lock_lost;
  assign lock_lost = (state_q == LOCKED) && (state_d == SEARCH);
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      err_q <= '0;
    end else if (lock_lost && err_q != 16'hFFFF) begin
      err_q <= err_q + 16'd1;
    end
  end
  assign o_err_cnt = err_q;
`else
  assign o_err_cnt = '0;
`endif

endmodule

// File: tb/tb_tmds_decoder.sv
// Directed bench for tmds_decoder: lock, decode, loss of lock, bit-slip cadence, reset mid-lock.
module tb_tmds_decoder;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [9:0]  tmds;
  logic [7:0]  pixel;
  logic [1:0]  ctrl;
  logic        de, locked, bitslip;
  logic [15:0] err_cnt;

  int total = 0;
  int bad   = 0;

  localparam logic [9:0] C00 = 10'b1101010100;
  localparam logic [9:0] C01 = 10'b0010101011;
  localparam logic [9:0] C10 = 10'b0101010100;
  localparam logic [9:0] C11 = 10'b1010101011;
  localparam logic [9:0] D0  = 10'b0100000000; // -> 8'h00
  localparam logic [9:0] D1  = 10'b1011111111; // q=00, xnor chain -> 8'hFE
  localparam logic [9:0] D2  = 10'b0100000001; // q=01, xor chain  -> 8'h03

`ifdef TMDS_DEC_ERR_CNT_EN
  localparam logic [15:0] ERR_EXP = 16'd1;
`else
  localparam logic [15:0] ERR_EXP = 16'd0;
`endif

  tmds_decoder #(.SEARCH_LEN(16), .CTRL_RUN(8)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_tmds(tmds),
    .o_pixel(pixel), .o_ctrl(ctrl), .o_de(de), .o_locked(locked),
    .o_bitslip(bitslip), .o_err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  task automatic step(input logic [9:0] sym);
    tmds = sym;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic check_zero_outs(input string tag);
    check({tag, "_pixel"},   16'(pixel),   16'h00);
    check({tag, "_ctrl"},    16'(ctrl),    16'h0);
    check({tag, "_de"},      16'(de),      16'h0);
    check({tag, "_locked"},  16'(locked),  16'h0);
    check({tag, "_bitslip"}, 16'(bitslip), 16'h0);
  endtask

  initial begin
    rst_n = 1'b0;
    tmds  = '0;
    step(D1);
    step(D1);
    check_zero_outs("reset");
    check("reset_err", err_cnt, 16'h0);

    // Lock on 8 C00 tokens
    rst_n = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      step(C00);
      check("lock_pending", 16'(locked), 16'h0);
      if (i >= 2) begin
        check("tok_de", 16'(de), 16'h0);
        check("tok_ctrl", 16'(ctrl), 16'h0);
      end
    end
    step(D0);
    check("locked_after_8", 16'(locked), 16'h1);
    check("tok8_de", 16'(de), 16'h0);
    step(D1);
    check("d0_de", 16'(de), 16'h1);
    check("d0_pixel", 16'(pixel), 16'h00);
    step(D2);
    check("d1_pixel", 16'(pixel), 16'hFE);
    step(C11);
    check("d2_pixel", 16'(pixel), 16'h03);
    step(C10);
    check("c11_de", 16'(de), 16'h0);
    check("c11_ctrl", 16'(ctrl), 16'h3);
    check("c11_pixel_hold", 16'(pixel), 16'h03);
    step(C01);
    check("c10_ctrl", 16'(ctrl), 16'h2);

    // 16 data symbols while locked -> lock lost one edge after the 16th is evaluated
    for (int i = 1; i <= 16; i++) begin
      step(D0);
      check("still_locked", 16'(locked), 16'h1);
      check("locked_no_slip", 16'(bitslip), 16'h0);
      if (i == 1) check("c01_ctrl", 16'(ctrl), 16'h1);
      if (i == 2) check("c01_ctrl_hold", 16'(ctrl), 16'h1);
    end
    step(D0);
    check("lock_lost", 16'(locked), 16'h0);
    check("lock_lost_slip", 16'(bitslip), 16'h0);
    check("err_cnt", err_cnt, ERR_EXP);
    check("data_de", 16'(de), 16'h1);

    // Bit-slip cadence on constant data
    rst_n = 1'b0;
    step(D0);
    step(D0);
    check("rst2_slip", 16'(bitslip), 16'h0);
    check("rst2_err", err_cnt, 16'h0);
    rst_n = 1'b1;
    for (int k = 1; k <= 70; k++) begin
      step(D0);
      check($sformatf("slip_k%0d", k), 16'(bitslip),
            (k == 16 || k == 40 || k == 64) ? 16'h1 : 16'h0);
      check("slip_unlocked", 16'(locked), 16'h0);
    end

    // Interrupted run, then a full run, then reset mid-lock
    rst_n = 1'b0;
    step(C00);
    rst_n = 1'b1;
    for (int i = 1; i <= 7; i++) step(C00);
    step(D1);
    for (int i = 1; i <= 8; i++) begin
      step(C11);
      check("run2_pending", 16'(locked), 16'h0);
    end
    step(C11);
    check("run2_locked", 16'(locked), 16'h1);
    check("run2_ctrl", 16'(ctrl), 16'h3);
    check("run2_pixel", 16'(pixel), 16'hFE);
    rst_n = 1'b0;
    step(C11);
    check_zero_outs("midlock_rst");
    rst_n = 1'b1;
    step(C11);
    check_zero_outs("post_rel1");
    step(C11);
    check("post_rel2_ctrl", 16'(ctrl), 16'h3);
    check("post_rel2_de", 16'(de), 16'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
